// File: rtl/cgra_input_read_scheduler.sv
// Strided read sequencer for CGRA input channels sharing one AXI-Lite read port.
// Round-robin arbitration, one outstanding read, one-entry buffer per channel.
module cgra_input_read_scheduler #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SIZE_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     execute_i,
  input  logic [N_CH*ADDR_W-1:0]   base_addr_i,
  input  logic [N_CH*SIZE_W-1:0]   size_i,
  input  logic [N_CH*SIZE_W-1:0]   stride_i,
  output logic [ADDR_W-1:0]        ar_addr_o,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  input  logic [DATA_W-1:0]        r_data_i,
  input  logic [1:0]               r_resp_i,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  output logic [N_CH*DATA_W-1:0]   data_o,
  output logic [N_CH-1:0]          data_valid_o,
  input  logic [N_CH-1:0]          data_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o
);

  localparam int unsigned PtrW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StArb, StAr, StR} state_e;

  state_e                         state_q, state_d;
  logic [N_CH-1:0][ADDR_W-1:0]    base_q, base_d;
  logic [N_CH-1:0][SIZE_W-1:0]    size_q, size_d;
  logic [N_CH-1:0][SIZE_W-1:0]    stride_q, stride_d;
  // One extra bit so offset + stride can never wrap back below size.
  logic [N_CH-1:0][SIZE_W:0]      offset_q, offset_d;
  logic [PtrW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]                winner_q, winner_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [N_CH-1:0][DATA_W-1:0]    buf_data_q, buf_data_d;
  logic [N_CH-1:0]                buf_valid_q, buf_valid_d;
  logic                           error_q, error_d;

  logic [N_CH-1:0]                pending, eligible;
  logic                           found;
  logic [PtrW-1:0]                found_idx, cand;

  // Per-channel pending/eligible; a buffer drained this cycle counts as free.
  always_comb begin
    pending  = '0;
    eligible = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pending[i]  = offset_q[i] < {1'b0, size_q[i]};
      eligible[i] = pending[i] & (~buf_valid_q[i] | data_ready_i[i]);
    end
  end

  // First eligible channel at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % N_CH);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        found_idx = cand;
      end
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    size_d      = size_q;
    stride_d    = stride_q;
    offset_d    = offset_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    addr_d      = addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    error_d     = error_q;
    ar_valid_o  = 1'b0;
    r_ready_o   = 1'b0;
    done_o      = 1'b0;

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (buf_valid_q[i] && data_ready_i[i]) buf_valid_d[i] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (execute_i) begin
          for (int unsigned i = 0; i < N_CH; i++) begin
            base_d[i]   = base_addr_i[i*ADDR_W +: ADDR_W];
            size_d[i]   = size_i[i*SIZE_W +: SIZE_W];
            stride_d[i] = stride_i[i*SIZE_W +: SIZE_W];
          end
          offset_d = '0;
          error_d  = 1'b0;
          state_d  = StArb;
        end
      end
      StArb: begin
        if (found) begin
          rr_ptr_d = PtrW'((32'(found_idx) + 32'd1) % N_CH);
          winner_d = found_idx;
          addr_d   = base_q[found_idx] + ADDR_W'(offset_q[found_idx]);
          state_d  = StAr;
        end else if (pending == '0 && buf_valid_q == '0) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
      end
      StAr: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          if (stride_q[winner_q] == '0) begin
            offset_d[winner_q] = {1'b0, size_q[winner_q]};
          end else begin
            offset_d[winner_q] = offset_q[winner_q] + {1'b0, stride_q[winner_q]};
          end
          state_d = StR;
        end
      end
      StR: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          buf_data_d[winner_q]  = r_data_i;
          buf_valid_d[winner_q] = 1'b1;
          if (r_resp_i != 2'b00) error_d = 1'b1;
          state_d = StArb;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      size_q      <= '0;
      stride_q    <= '0;
      offset_q    <= '0;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      addr_q      <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      size_q      <= size_d;
      stride_q    <= stride_d;
      offset_q    <= offset_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      addr_q      <= addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      error_q     <= error_d;
    end
  end

  assign ar_addr_o    = addr_q;
  assign data_o       = buf_data_q;
  assign data_valid_o = buf_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign error_o      = error_q;

endmodule
